// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shadow pipeline of writer records, youngest-match forwarding and Tnew/Tuse stall.
// Optional mult/div busy interlock enabled by defining HAZARD_MD_EN.
module hazard_scoreboard #(
    parameter int NSTG     = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    localparam int SW      = $clog2(NSTG + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic          d_we,
    input  logic [4:0]    d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [SW-1:0] fwd_d_rs,
    output logic [SW-1:0] fwd_d_rt,
    output logic [SW-1:0] fwd_e_rs,
    output logic [SW-1:0] fwd_e_rt,
    output logic [SW-1:0] fwd_m_rt,
    output logic          md_busy
);

    logic          r_valid [1:NSTG];
    logic          r_we    [1:NSTG];
    logic [4:0]    r_dst   [1:NSTG];
    logic [TW-1:0] r_tnew  [1:NSTG];
    logic [4:0]    r_rs    [1:NSTG];
    logic [4:0]    r_rt    [1:NSTG];

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_md_stall;
    logic w_stall;

    function automatic logic rec_hit(input int unsigned k, input logic [4:0] s);
        return r_valid[k] && r_we[k] && (r_dst[k] == s) && (r_dst[k] != 5'd0);
    endfunction

    // Scan oldest to youngest so the lowest matching stage overrides older ones.
    function automatic logic [SW-1:0] fwd_sel(input logic [4:0] s, input int unsigned p);
        logic [SW-1:0] sel;
        sel = '0;
        for (int unsigned k = NSTG; k > p; k--) begin
            if (rec_hit(k, s)) begin
                sel = (r_tnew[k] == '0) ? SW'(k) : '0;
            end
        end
        return sel;
    endfunction

    function automatic logic src_stall(input logic [4:0] s, input logic [TW-1:0] tuse);
        logic st;
        st = 1'b0;
        for (int unsigned k = NSTG; k > 0; k--) begin
            if (rec_hit(k, s)) begin
                st = (r_tnew[k] > tuse);
            end
        end
        return st;
    endfunction

    always_comb begin
        w_stall_rs = d_use_rs && src_stall(d_rs, d_tuse_rs);
        w_stall_rt = d_use_rt && src_stall(d_rt, d_tuse_rt);
        w_stall    = w_stall_rs || w_stall_rt || w_md_stall;
    end

    assign stall    = w_stall;
    assign fwd_d_rs = fwd_sel(d_rs, 0);
    assign fwd_d_rt = fwd_sel(d_rt, 0);
    assign fwd_e_rs = fwd_sel(r_rs[1], 1);
    assign fwd_e_rt = fwd_sel(r_rt[1], 1);
    assign fwd_m_rt = fwd_sel(r_rt[2], 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 1; k <= NSTG; k++) begin
                r_valid[k] <= 1'b0;
                r_we[k]    <= 1'b0;
                r_dst[k]   <= '0;
                r_tnew[k]  <= '0;
                r_rs[k]    <= '0;
                r_rt[k]    <= '0;
            end
        end else begin
            // A bubble clears every field so it cannot be picked up as a consumer source.
            if (w_stall) begin
                r_valid[1] <= 1'b0;
                r_we[1]    <= 1'b0;
                r_dst[1]   <= '0;
                r_tnew[1]  <= '0;
                r_rs[1]    <= '0;
                r_rt[1]    <= '0;
            end else begin
                r_valid[1] <= 1'b1;
                r_we[1]    <= d_we;
                r_dst[1]   <= d_dst;
                r_tnew[1]  <= d_tnew;
                r_rs[1]    <= d_rs;
                r_rt[1]    <= d_rt;
            end
            for (int unsigned k = 2; k <= NSTG; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_dst[k]   <= r_dst[k-1];
                r_tnew[k]  <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - 1'b1 : '0;
                r_rs[k]    <= r_rs[k-1];
                r_rt[k]    <= r_rt[k-1];
            end
        end
    end

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [CW-1:0] r_md_cnt;
    logic          r_md_issued;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt    <= '0;
            r_md_issued <= 1'b0;
        end else begin
            if (!w_stall && d_md_start) begin
                r_md_cnt <= d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - 1'b1;
            end
            r_md_issued <= !w_stall && d_md_start;
        end
    end

    assign w_md_stall = d_md_use && ((r_md_cnt != '0) || r_md_issued);
    assign md_busy    = (r_md_cnt != '0);
`else
    logic w_md_unused;
    assign w_md_unused = (^{d_md_start, d_md_div, d_md_use}) ^ (MULT_CYC != DIV_CYC);
    assign w_md_stall  = 1'b0;
    assign md_busy     = 1'b0;
`endif

endmodule
